// File: rtl/turn_input_cond_pkg.sv
// rtl/turn_input_cond_pkg.sv - car_defs shared constants for the tail-light front end and sequencer
package turn_input_cond_pkg;

  localparam int DEB_CYCLES_DEF = 1_000_000;
  localparam int DEB_W_DEF      = 20;
  localparam int TICK_DIV_DEF   = 8_388_608;
  localparam int TICK_W_DEF     = 24;

  // Three lamps per side, outermost bit lit last in the sweep.
  localparam logic [2:0] LED_OFF   = 3'b000;
  localparam logic [2:0] LED_STEP1 = 3'b001;
  localparam logic [2:0] LED_STEP2 = 3'b011;
  localparam logic [2:0] LED_STEP3 = 3'b111;

  typedef struct packed {
    logic left;
    logic right;
    logic haz;
  } sel_t;

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - 2-flop synchronizer plus counter-based debouncer with stable level q
module debounce_ch #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int DEB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic q
);

  localparam logic [DEB_W-1:0] LP_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_q;
  logic [DEB_W-1:0] r_cnt;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_q   <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= raw;
      r_s2 <= r_s1;
      // Any agreeing cycle restarts the count, so short glitches are dropped.
      if (r_s2 == r_q) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_LAST) begin
        r_q   <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DEB_W'(1);
      end
    end
  end

  assign q = r_q;

endmodule

// File: rtl/turn_input_cond.sv
// rtl/turn_input_cond.sv - lever/hazard conditioner with hazard toggle and resyncing step enable
module turn_input_cond
  import turn_input_cond_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DEB_W      = DEB_W_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int TICK_W     = TICK_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_l,
  input  logic raw_r,
  input  logic raw_halt,
  output logic l,
  output logic r,
  output logic hazard,
  output logic step_en
);

  localparam logic [TICK_W-1:0] LP_TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] LP_TICK_PEN  = TICK_W'(TICK_DIV - 2);

  logic              w_l_q;
  logic              w_r_q;
  logic              w_halt_q;
  sel_t              w_sel;
  logic              w_resync;
  logic              r_halt_d;
  logic              r_hazard;
  sel_t              r_prev;
  logic [TICK_W-1:0] r_tick;
  logic              r_step;

  debounce_ch #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_l (
    .clk(clk), .rst(rst), .raw(raw_l), .q(w_l_q)
  );
  debounce_ch #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_r (
    .clk(clk), .rst(rst), .raw(raw_r), .q(w_r_q)
  );
  debounce_ch #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_halt (
    .clk(clk), .rst(rst), .raw(raw_halt), .q(w_halt_q)
  );

  assign w_sel    = {w_l_q, w_r_q, r_hazard};
  assign w_resync = (w_sel != r_prev);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_halt_d <= 1'b0;
      r_hazard <= 1'b0;
      r_prev   <= '0;
      r_tick   <= '0;
      r_step   <= 1'b0;
    end else begin
      r_halt_d <= w_halt_q;
      if (w_halt_q && !r_halt_d) begin
        r_hazard <= ~r_hazard;
      end
      r_prev <= w_sel;
      // A new selection restarts the sweep, overriding a terminal count.
      if (w_resync || (r_tick == LP_TICK_LAST)) begin
        r_tick <= '0;
        r_step <= 1'b0;
      end else begin
        r_tick <= r_tick + TICK_W'(1);
        r_step <= (r_tick == LP_TICK_PEN);
      end
    end
  end

  assign l       = w_l_q;
  assign r       = w_r_q;
  assign hazard  = r_hazard;
  assign step_en = r_step;

endmodule

// File: tb/tb_turn_input_cond.sv
// tb/tb_turn_input_cond.sv - directed bench for turn_input_cond with DEB_CYCLES=4, TICK_DIV=8
module tb_turn_input_cond;

  logic clk      = 1'b0;
  logic rst      = 1'b0;
  logic raw_l    = 1'b0;
  logic raw_r    = 1'b0;
  logic raw_halt = 1'b0;
  logic l, r, hazard, step_en;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0    = 0;

  always #5 clk = ~clk;

  turn_input_cond #(
    .DEB_CYCLES(4), .DEB_W(3), .TICK_DIV(8), .TICK_W(4)
  ) dut (
    .clk(clk), .rst(rst), .raw_l(raw_l), .raw_r(raw_r), .raw_halt(raw_halt),
    .l(l), .r(r), .hazard(hazard), .step_en(step_en)
  );

  // Design acts on negedge; the bench drives and samples on posedge.
  task automatic tick();
    @(posedge clk);
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s at cycle %0d: observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    repeat (3) tick();
    check("reset_l", l, 1'b0);
    check("reset_r", r, 1'b0);
    check("reset_hazard", hazard, 1'b0);
    check("reset_step", step_en, 1'b0);

    rst = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      check("idle_step", step_en, (k % 8) == 7);
    end

    raw_r = 1'b1;
    run_to(29);
    check("r_pre", r, 1'b0);
    tick();
    check("r_rise", r, 1'b1);
    for (int k = 31; k <= 39; k++) begin
      tick();
      check("resync_step", step_en, k == 38);
    end

    for (int p = 0; p < 5; p++) begin
      raw_l = 1'b1;
      repeat (3) begin
        tick();
        check("glitch_l", l, 1'b0);
      end
      raw_l = 1'b0;
      tick();
      check("glitch_l", l, 1'b0);
    end
    repeat (6) begin
      tick();
      check("glitch_tail_l", l, 1'b0);
    end

    raw_l = 1'b1;
    t0 = cyc;
    run_to(t0 + 5);
    check("l_pre", l, 1'b0);
    tick();
    check("l_rise", l, 1'b1);

    raw_halt = 1'b1;
    t0 = cyc;
    run_to(t0 + 6);
    check("haz1_pre", hazard, 1'b0);
    tick();
    check("haz1_toggle", hazard, 1'b1);
    run_to(t0 + 20);
    check("haz1_hold", hazard, 1'b1);
    raw_halt = 1'b0;
    t0 = cyc;
    run_to(t0 + 12);
    check("haz_release", hazard, 1'b1);
    raw_halt = 1'b1;
    t0 = cyc;
    run_to(t0 + 6);
    check("haz2_pre", hazard, 1'b1);
    tick();
    check("haz2_toggle", hazard, 1'b0);
    raw_halt = 1'b0;
    t0 = cyc;
    run_to(t0 + 10);
    raw_halt = 1'b1;
    t0 = cyc;
    run_to(t0 + 7);
    check("haz3_toggle", hazard, 1'b1);

    raw_l = 1'b0;
    raw_r = 1'b0;
    repeat (4) tick();
    check("l_partial", l, 1'b1);
    rst = 1'b0;
    #1;
    check("midrst_l", l, 1'b0);
    check("midrst_r", r, 1'b0);
    check("midrst_hazard", hazard, 1'b0);
    check("midrst_step", step_en, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("postrst_step", step_en, (k == 7) || (k == 15));
      check("postrst_hazard", hazard, k >= 7);
      check("postrst_l", l, 1'b0);
    end

    raw_halt = 1'b0;
    t0 = cyc;
    run_to(t0 + 8);
    raw_halt = 1'b1;
    t0 = cyc;
    tick();
    raw_l = 1'b1;
    raw_r = 1'b1;
    run_to(t0 + 6);
    check("sim_l_pre", l, 1'b0);
    check("sim_r_pre", r, 1'b0);
    check("sim_haz_pre", hazard, 1'b1);
    tick();
    check("sim_l", l, 1'b1);
    check("sim_r", r, 1'b1);
    check("sim_haz", hazard, 1'b0);
    for (int k = 8; k <= 16; k++) begin
      tick();
      check("sim_step", step_en, k == 15);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
